// File: rtl/accelerator_package.sv
// Types for the accelerator's Z output path: job parameters, Z store FSM states and
// the store progress counters.
package accelerator_package;

    typedef struct packed {
        logic [31:0] base_addr;
        logic [15:0] y_columns;
        logic [15:0] y_row_iters;
    } Z_param_t;

    typedef enum logic [2:0] {
        ZS_IDLE,
        ZS_SETTLE,
        ZS_WAIT_DATA,
        ZS_ISSUE,
        ZS_WAIT_DONE,
        ZS_FINISH
    } z_store_state_e;

    typedef struct packed {
        logic [15:0] col_block;
        logic [15:0] row;
        logic [31:0] blocks_stored;
    } z_store_status_t;

    // True when the block currently being stored is the final one of the job.
    function automatic logic is_last_block(input z_store_status_t st,
                                           input logic [15:0]     row_iters,
                                           input logic [15:0]     n_rows);
        return (16'(st.col_block + 16'd1) == row_iters) &&
               (16'(st.row + 16'd1) == n_rows);
    endfunction

endpackage

// File: rtl/hci_package.sv
// Streamer control/flag types shared by every HCI source and sink streamer.
package hci_package;

    typedef struct packed {
        logic        req_start;
        logic [31:0] base_addr;
        logic [31:0] tot_len;
        logic [31:0] d0_len;
        logic [31:0] d0_stride;
    } hci_streamer_ctrl_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } hci_streamer_flags_t;

endpackage

// File: rtl/z_store_controller_watchdog.sv
// Transaction watchdog: counts cycles while a streamer transaction is outstanding and
// flags expiry once the limit is reached.
module store_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = count_en_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/z_store_controller.sv
// Z store controller: walks the Z blocks of a job, hands each finished accumulator block
// to the sink streamer and advances the Z scheduler once the block is stored.
module z_store_controller
    import accelerator_package::*;
    import hci_package::*;
#(
    parameter int unsigned BW             = 128,
    parameter int unsigned SCHED_LAT      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                start_i,
    input  Z_param_t            params_i,
    input  logic [15:0]         n_rows_i,
    input  hci_streamer_ctrl_t  sched_config_i,
    output logic                sched_working_o,
    output logic                sched_done_o,
    output logic                sched_proceed_o,
    input  logic                acc_valid_i,
    output logic                acc_release_o,
    output hci_streamer_ctrl_t  stream_ctrl_o,
    input  hci_streamer_flags_t stream_flags_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [31:0]         blocks_stored_o
);

    localparam logic [15:0] SETTLE_LOAD = (SCHED_LAT > 0) ? 16'(SCHED_LAT - 1) : 16'd0;
    localparam logic [31:0] BW_U        = 32'(BW);

    z_store_state_e     state_q, state_d;
    hci_streamer_ctrl_t ctrl_q, ctrl_d;
    z_store_status_t    status_q, status_d;
    logic [15:0]        n_rows_q, n_rows_d;
    logic [15:0]        iters_q, iters_d;
    logic [15:0]        settle_q, settle_d;
    logic               error_q, error_d;
    logic [15:0]        col_next;
    logic               wd_restart;
    logic               wd_expired;
    logic               kill;

    // Z base address and column count are consumed by the scheduler, not by this block.
    logic unused_inputs;
    assign unused_inputs = ^{params_i.base_addr, params_i.y_columns, BW_U[0]};

    assign kill     = rst_i | clear_i;
    assign col_next = status_q.col_block + 16'd1;

    store_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .restart_i  (wd_restart),
        .count_en_i ((state_q == ZS_ISSUE) || (state_q == ZS_WAIT_DONE)),
        .expired_o  (wd_expired)
    );

    // NOTE: every variable gets its default first so no path through the case infers a latch.
    always_comb begin
        state_d         = state_q;
        ctrl_d          = ctrl_q;
        status_d        = status_q;
        n_rows_d        = n_rows_q;
        iters_d         = iters_q;
        settle_d        = settle_q;
        error_d         = error_q;
        wd_restart      = 1'b0;
        acc_release_o   = 1'b0;
        sched_proceed_o = 1'b0;

        unique case (state_q)
            ZS_IDLE: begin
                if (start_i) begin
                    n_rows_d = n_rows_i;
                    iters_d  = params_i.y_row_iters;
                    status_d = '0;
                    error_d  = 1'b0;
                    settle_d = SETTLE_LOAD;
                    state_d  = ((n_rows_i == 16'd0) || (params_i.y_row_iters == 16'd0))
                               ? ZS_FINISH : ZS_SETTLE;
                end
            end
            ZS_SETTLE: begin
                if (settle_q == 16'd0) begin
                    state_d = ZS_WAIT_DATA;
                end else begin
                    settle_d = settle_q - 16'd1;
                end
            end
            ZS_WAIT_DATA: begin
                if (acc_valid_i) begin
                    ctrl_d           = sched_config_i;
                    ctrl_d.req_start = 1'b1;
                    wd_restart       = 1'b1;
                    state_d          = ZS_ISSUE;
                end
            end
            ZS_ISSUE: begin
                // Forward progress beats the watchdog when both land in the same cycle.
                if (ctrl_q.req_start && stream_flags_i.ready_start) begin
                    ctrl_d.req_start = 1'b0;
                    state_d          = ZS_WAIT_DONE;
                end else if (wd_expired) begin
                    ctrl_d.req_start = 1'b0;
                    error_d          = 1'b1;
                    state_d          = ZS_IDLE;
                end
            end
            ZS_WAIT_DONE: begin
                if (stream_flags_i.done) begin
                    acc_release_o          = 1'b1;
                    sched_proceed_o        = 1'b1;
                    status_d.blocks_stored = status_q.blocks_stored + 32'd1;
                    settle_d               = SETTLE_LOAD;
                    state_d                = is_last_block(status_q, iters_q, n_rows_q)
                                             ? ZS_FINISH : ZS_SETTLE;
                    if (col_next == iters_q) begin
                        status_d.col_block = '0;
                        status_d.row       = status_q.row + 16'd1;
                    end else begin
                        status_d.col_block = col_next;
                    end
                end else if (wd_expired) begin
                    error_d = 1'b1;
                    state_d = ZS_IDLE;
                end
            end
            ZS_FINISH: begin
                state_d = ZS_IDLE;
            end
            default: begin
                state_d = ZS_IDLE;
            end
        endcase

        if (kill) begin
            state_d         = ZS_IDLE;
            ctrl_d          = '0;
            status_d        = '0;
            n_rows_d        = '0;
            iters_d         = '0;
            settle_d        = '0;
            error_d         = 1'b0;
            wd_restart      = 1'b1;
            acc_release_o   = 1'b0;
            sched_proceed_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ZS_IDLE;
            ctrl_q   <= '0;
            status_q <= '0;
            n_rows_q <= '0;
            iters_q  <= '0;
            settle_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            n_rows_q <= n_rows_d;
            iters_q  <= iters_d;
            settle_q <= settle_d;
            error_q  <= error_d;
        end
    end

    assign stream_ctrl_o   = ctrl_q;
    assign error_o         = error_q;
    assign blocks_stored_o = status_q.blocks_stored;
    assign busy_o          = (state_q != ZS_IDLE);
    assign sched_working_o = (state_q != ZS_IDLE) && (state_q != ZS_FINISH);
    assign done_o          = (state_q == ZS_FINISH) && !kill;
    assign sched_done_o    = (state_q == ZS_FINISH) && !kill;

endmodule

// File: tb/tb_z_store_controller.sv
// Directed bench for z_store_controller: a small streamer model answers req_start and
// reports done, while each task drives one scenario and checks its own results.
module tb_z_store_controller;
    import accelerator_package::*;
    import hci_package::*;

    localparam hci_streamer_ctrl_t CFG_A = '{req_start: 1'b0, base_addr: 32'h1000_0040,
        tot_len: 32'd48, d0_len: 32'd16, d0_stride: 32'd16};
    localparam hci_streamer_ctrl_t CFG_B = '{req_start: 1'b0, base_addr: 32'h2000_0100,
        tot_len: 32'd32, d0_len: 32'd8, d0_stride: 32'd4};

    logic                clk_i = 1'b0;
    logic                rst_i, clear_i, start_i, acc_valid_i;
    Z_param_t            params_i;
    logic [15:0]         n_rows_i;
    hci_streamer_ctrl_t  sched_config_i, stream_ctrl_o;
    hci_streamer_flags_t stream_flags_i;
    logic                sched_working_o, sched_done_o, sched_proceed_o, acc_release_o;
    logic                busy_o, done_o, error_o;
    logic [31:0]         blocks_stored_o;

    int n_cmp = 0;
    int n_err = 0;

    // Streamer model configuration and state.
    int   rdy_wait   = 0;
    int   done_lat   = -1;
    logic force_done = 1'b0;
    int   m_issue_n  = 0;
    int   m_wait_n   = 0;
    bit   m_pending  = 1'b0;
    logic m_ready    = 1'b0;
    logic m_done     = 1'b0;

    // Event counters sampled mid-cycle by the monitor.
    int acc_cnt = 0, rel_cnt = 0, prc_cnt = 0, done_cnt = 0, sdone_cnt = 0;

    z_store_controller #(
        .BW             (128),
        .SCHED_LAT      (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clear_i         (clear_i),
        .start_i         (start_i),
        .params_i        (params_i),
        .n_rows_i        (n_rows_i),
        .sched_config_i  (sched_config_i),
        .sched_working_o (sched_working_o),
        .sched_done_o    (sched_done_o),
        .sched_proceed_o (sched_proceed_o),
        .acc_valid_i     (acc_valid_i),
        .acc_release_o   (acc_release_o),
        .stream_ctrl_o   (stream_ctrl_o),
        .stream_flags_i  (stream_flags_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .blocks_stored_o (blocks_stored_o)
    );

    always #5 clk_i = ~clk_i;

    assign stream_flags_i.ready_start = m_ready;
    assign stream_flags_i.done        = m_done | force_done;

    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            m_ready = 1'b0;
            m_done  = 1'b0;
            if (!busy_o) m_pending = 1'b0;
            if (m_pending) begin
                m_wait_n++;
                if (done_lat >= 0 && m_wait_n >= done_lat) begin
                    m_done    = 1'b1;
                    m_pending = 1'b0;
                end
            end
            if (stream_ctrl_o.req_start) begin
                if (m_issue_n >= rdy_wait) begin
                    m_ready   = 1'b1;
                    m_pending = 1'b1;
                    m_wait_n  = 0;
                end
                m_issue_n++;
            end else begin
                m_issue_n = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (stream_ctrl_o.req_start && stream_flags_i.ready_start) acc_cnt++;
            if (acc_release_o)   rel_cnt++;
            if (sched_proceed_o) prc_cnt++;
            if (done_o)          done_cnt++;
            if (sched_done_o)    sdone_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_err);
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clr_counts();
        acc_cnt = 0; rel_cnt = 0; prc_cnt = 0; done_cnt = 0; sdone_cnt = 0;
    endtask

    task automatic launch(input logic [15:0] rows, input logic [15:0] iters);
        params_i = '{base_addr: 32'h8000_0000, y_columns: 16'd4, y_row_iters: iters};
        n_rows_i = rows;
        start_i  = 1'b1;
        step();
        start_i  = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) step();
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_cmp++; if (stream_ctrl_o !== '0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 0", stream_ctrl_o); end
        n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b expected 0", error_o); end
        n_cmp++; if (blocks_stored_o !== 32'd0) begin n_err++; $display("FAIL reset_blocks: got %0d expected 0", blocks_stored_o); end
        n_cmp++; if ({done_o, sched_done_o, sched_working_o, acc_release_o, sched_proceed_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_pulses: got %b expected 00000",
                {done_o, sched_done_o, sched_working_o, acc_release_o, sched_proceed_o});
        end
        rst_i = 1'b0;
        step();
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_full_job();
        int lat;
        bit seen;
        sched_config_i = CFG_A;
        acc_valid_i    = 1'b1;
        rdy_wait       = 0;
        done_lat       = 4;
        clr_counts();
        launch(16'd2, 16'd3);
        n_cmp++; if ({busy_o, sched_working_o} !== 2'b11) begin n_err++; $display("FAIL job_working: got %b expected 11", {busy_o, sched_working_o}); end
        lat = 1;
        while (stream_ctrl_o.req_start !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL settle_latency: got %0d expected 4", lat); end
        wait_done(400, seen);
        n_cmp++; if (!seen) begin n_err++; $display("FAIL job_done_seen: got 0 expected 1"); end
        n_cmp++; if (acc_cnt != 6) begin n_err++; $display("FAIL job_accepts: got %0d expected 6", acc_cnt); end
        n_cmp++; if (rel_cnt != 6) begin n_err++; $display("FAIL job_releases: got %0d expected 6", rel_cnt); end
        n_cmp++; if (prc_cnt != 6) begin n_err++; $display("FAIL job_proceeds: got %0d expected 6", prc_cnt); end
        n_cmp++; if (blocks_stored_o !== 32'd6) begin n_err++; $display("FAIL job_blocks: got %0d expected 6", blocks_stored_o); end
        n_cmp++; if (sched_done_o !== 1'b1) begin n_err++; $display("FAIL job_sched_done: got %b expected 1", sched_done_o); end
        step();
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL job_done_pulses: got %0d expected 1", done_cnt); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL job_idle: got %b expected 0", busy_o); end
        n_cmp++; if (stream_ctrl_o.base_addr !== CFG_A.base_addr || stream_ctrl_o.req_start !== 1'b0) begin
            n_err++; $display("FAIL job_ctrl: got %h expected base %h req 0", stream_ctrl_o, CFG_A.base_addr);
        end
    endtask

    task automatic test_hold_idle();
        repeat (5) step();
        n_cmp++; if (blocks_stored_o !== 32'd6) begin n_err++; $display("FAIL idle_hold_blocks: got %0d expected 6", blocks_stored_o); end
        n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL idle_hold_error: got %b expected 0", error_o); end
    endtask

    task automatic test_zero_rows();
        clr_counts();
        launch(16'd0, 16'd3);
        n_cmp++; if ({done_o, sched_done_o, busy_o, sched_working_o} !== 4'b1110) begin
            n_err++; $display("FAIL zero_rows_finish: got %b expected 1110", {done_o, sched_done_o, busy_o, sched_working_o});
        end
        n_cmp++; if (blocks_stored_o !== 32'd0) begin n_err++; $display("FAIL zero_rows_blocks: got %0d expected 0", blocks_stored_o); end
        step();
        n_cmp++; if ({done_o, busy_o} !== 2'b00) begin n_err++; $display("FAIL zero_rows_idle: got %b expected 00", {done_o, busy_o}); end
        launch(16'd5, 16'd0);
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL zero_iters_finish: got %b expected 1", done_o); end
        step();
        n_cmp++; if (acc_cnt != 0) begin n_err++; $display("FAIL zero_jobs_accepts: got %0d expected 0", acc_cnt); end
    endtask

    task automatic test_ready_withheld();
        hci_streamer_ctrl_t first;
        bit have_first, changed, seen;
        int withheld;
        have_first = 1'b0; changed = 1'b0; withheld = 0;
        sched_config_i = CFG_B;
        rdy_wait = 10;
        done_lat = 2;
        clr_counts();
        launch(16'd1, 16'd1);
        for (int k = 0; k < 200 && done_o !== 1'b1; k++) begin
            if (stream_ctrl_o.req_start === 1'b1) begin
                if (!have_first) begin
                    first = stream_ctrl_o;
                    have_first = 1'b1;
                end else if (stream_ctrl_o !== first) begin
                    changed = 1'b1;
                end
                if (stream_flags_i.ready_start !== 1'b1) withheld++;
                if (withheld == 3) sched_config_i.base_addr = 32'hDEAD_BEEF;
            end
            step();
        end
        seen = (done_o === 1'b1);
        n_cmp++; if (!seen) begin n_err++; $display("FAIL withheld_done_seen: got 0 expected 1"); end
        n_cmp++; if (withheld != 10) begin n_err++; $display("FAIL withheld_req_cycles: got %0d expected 10", withheld); end
        n_cmp++; if (changed) begin n_err++; $display("FAIL withheld_ctrl_stable: got changing ctrl expected stable"); end
        n_cmp++; if (first.base_addr !== CFG_B.base_addr) begin n_err++; $display("FAIL withheld_capture: got %h expected %h", first.base_addr, CFG_B.base_addr); end
        n_cmp++; if (acc_cnt != 1) begin n_err++; $display("FAIL withheld_accepts: got %0d expected 1", acc_cnt); end
        n_cmp++; if (blocks_stored_o !== 32'd1) begin n_err++; $display("FAIL withheld_blocks: got %0d expected 1", blocks_stored_o); end
        step();
        sched_config_i = CFG_A;
        rdy_wait = 0;
    endtask

    task automatic test_timeout();
        int k;
        done_lat = -1;
        clr_counts();
        launch(16'd1, 16'd1);
        for (int j = 0; j < 20 && stream_ctrl_o.req_start !== 1'b1; j++) step();
        k = 0;
        while (error_o !== 1'b1 && k < 64) begin
            step();
            k++;
        end
        n_cmp++; if (k != 16) begin n_err++; $display("FAIL timeout_cycles: got %0d expected 16", k); end
        n_cmp++; if ({busy_o, stream_ctrl_o.req_start} !== 2'b00) begin
            n_err++; $display("FAIL timeout_idle: got %b expected 00", {busy_o, stream_ctrl_o.req_start});
        end
        repeat (4) step();
        n_cmp++; if (done_cnt != 0 || rel_cnt != 0) begin n_err++; $display("FAIL timeout_pulses: got done %0d rel %0d expected 0 0", done_cnt, rel_cnt); end
        n_cmp++; if (error_o !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b expected 1", error_o); end
    endtask

    task automatic test_clear_mid_job();
        bit seen;
        done_lat = -1;
        clr_counts();
        launch(16'd1, 16'd2);
        n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL start_clears_error: got %b expected 0", error_o); end
        for (int j = 0; j < 20 && acc_cnt == 0; j++) step();
        repeat (2) step();
        clear_i    = 1'b1;
        force_done = 1'b1;
        #1;
        n_cmp++; if ({acc_release_o, sched_proceed_o} !== 2'b00) begin
            n_err++; $display("FAIL clear_release_gated: got %b expected 00", {acc_release_o, sched_proceed_o});
        end
        step();
        clear_i    = 1'b0;
        force_done = 1'b0;
        n_cmp++; if ({busy_o, stream_ctrl_o.req_start} !== 2'b00) begin
            n_err++; $display("FAIL clear_idle: got %b expected 00", {busy_o, stream_ctrl_o.req_start});
        end
        n_cmp++; if (rel_cnt != 0 || done_cnt != 0) begin n_err++; $display("FAIL clear_pulses: got rel %0d done %0d expected 0 0", rel_cnt, done_cnt); end
        done_lat = 4;
        clr_counts();
        launch(16'd1, 16'd2);
        wait_done(200, seen);
        n_cmp++; if (!seen || blocks_stored_o !== 32'd2) begin
            n_err++; $display("FAIL clear_restart: got seen %0d blocks %0d expected 1 2", seen, blocks_stored_o);
        end
        step();
    endtask

    task automatic test_stray_inputs();
        bit seen;
        acc_valid_i = 1'b0;
        done_lat    = 4;
        clr_counts();
        launch(16'd1, 16'd2);
        repeat (4) step();
        force_done = 1'b1;
        #1;
        n_cmp++; if ({acc_release_o, sched_proceed_o} !== 2'b00) begin
            n_err++; $display("FAIL stray_done_release: got %b expected 00", {acc_release_o, sched_proceed_o});
        end
        step();
        force_done = 1'b0;
        n_cmp++; if (blocks_stored_o !== 32'd0 || busy_o !== 1'b1) begin
            n_err++; $display("FAIL stray_done_state: got blocks %0d busy %b expected 0 1", blocks_stored_o, busy_o);
        end
        acc_valid_i = 1'b1;
        for (int j = 0; j < 50 && blocks_stored_o != 32'd1; j++) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        n_cmp++; if (blocks_stored_o !== 32'd1 || busy_o !== 1'b1) begin
            n_err++; $display("FAIL busy_start_ignored: got blocks %0d busy %b expected 1 1", blocks_stored_o, busy_o);
        end
        wait_done(200, seen);
        step();
        n_cmp++; if (!seen || blocks_stored_o !== 32'd2 || done_cnt != 1 || acc_cnt != 2) begin
            n_err++; $display("FAIL stray_job_result: got seen %0d blocks %0d done %0d accepts %0d expected 1 2 1 2",
                seen, blocks_stored_o, done_cnt, acc_cnt);
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        clear_i        = 1'b0;
        start_i        = 1'b0;
        acc_valid_i    = 1'b0;
        params_i       = '0;
        n_rows_i       = '0;
        sched_config_i = '0;
        test_reset();
        test_full_job();
        test_hold_idle();
        test_zero_rows();
        test_ready_withheld();
        test_timeout();
        test_clear_mid_job();
        test_stray_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
